uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver; the receiving end of the serial link timed by baud_rate_gen.
//  Oversamples rx on each tick, recovers start/data/parity/stop, and presents the
//  byte through a valid/ready handshake with per-frame parity and framing status.
//  Shares csr with baud_rate_gen; csr[26:7] is the divisor there and is ignored here.
// PARAMETERS
//  OVERSAMPLE  16  ticks per bit period; even, >=4; tick_cnt width = $clog2(OVERSAMPLE)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  csr          in   32  [1:0] data len (00=5,01=6,10=7,11=8 bits); [2] parity en;
//                        [3] parity odd(1)/even(0); [4] 2 stop bits; [26:7] unused here
//  tick         in   1   1-clk pulse from baud_rate_gen, OVERSAMPLE per bit
//  rx           in   1   async serial line, idles high
//  rx_ready     in   1   consumer accepts rx_data when rx_valid&rx_ready
//  rx_data      out  8   received byte, LSB first on line; unused upper bits = 0
//  rx_valid     out  1   data held until accepted
//  parity_err   out  1   status of frame in rx_data; valid with rx_valid
//  frame_err    out  1   a stop bit sampled low; valid with rx_valid
//  overrun_err  out  1   1-clk pulse: frame completed while rx_valid&!rx_ready
//  busy         out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, all err=0, busy=0, FSM=IDLE, sync flops=1.
//    rst mid-frame aborts at the next edge; partial frame discarded.
//  - rx through 2-flop synchronizer; start = falling edge of synced rx (prev 1, now 0).
//  - tick_cnt advances only on tick; all sampling happens on tick cycles.
//  - IDLE: on start edge -> START, tick_cnt=0, latch csr[4:0] (mid-frame csr writes
//    take effect next frame).
//  - START: at tick_cnt==OVERSAMPLE/2-1, sample; 1 -> IDLE (glitch, no output);
//    0 -> DATA, tick_cnt=0, bit_idx=0. Start edge requires line high first (break safe).
//  - DATA: every OVERSAMPLE ticks sample into shift reg at bit_idx; after len bits
//    -> PARITY if parity en, else STOP.
//  - PARITY: sample; parity_err_n = (XOR(data bits, sampled bit) != odd_sel).
//  - STOP: sample; low sets frame_err_n. If 2-stop, sample a second stop -> STOP2.
//    Frame completes at last stop sample; FSM -> IDLE the same cycle (next start
//    edge may follow immediately).
//  - Completion: next clk after the final stop-sample tick, rx_data/parity_err/
//    frame_err load and rx_valid=1. Framed-error bytes are still delivered.
//  - Handshake: rx_valid&rx_ready clears rx_valid next clk unless a frame completes
//    that same cycle; then new frame loads, rx_valid stays 1, no overrun.
//  - Overrun: completion with rx_valid=1 and rx_ready=0 -> new frame overwrites,
//    rx_valid stays 1, overrun_err=1 for one clk.
//  - tick and start edge same cycle in IDLE: edge accepted; tick_cnt starts at 0.
//  - Counters: tick_cnt wraps 0..OVERSAMPLE-1; bit_idx 3 bits, never exceeds len-1.
// STRUCTURE
//  - uart_pkg: rx_state_e {IDLE,START,DATA,PARITY,STOP,STOP2}; CSR bit-index
//    localparams (CSR_LEN_LSB=0, CSR_PAR_EN=2, CSR_PAR_ODD=3, CSR_STOP2=4,
//    CSR_DIV_LSB=7, CSR_DIV_MSB=26); shared with baud_rate_gen and uart_tx.
//  - Sub-module uart_rx_sync: 2-flop synchronizer + falling-edge detect
//    (outputs rx_s, fall); rest is one FSM + datapath in uart_rx.
// TESTING  (baud_rate_gen with csr[26:7]=4, OVERSAMPLE=16)
//  - 8N1, send 0xA5, rx_ready=1 -> rx_valid 1 clk, rx_data=0xA5, both err=0.
//  - 7E1 0x35 with correct parity -> 0x35, parity_err=0; flip parity -> parity_err=1.
//  - 8N2, second stop forced low, byte 0x3C -> rx_data=0x3C, frame_err=1; line
//    held low after -> no new frame until rx returns high.
//  - Low glitch of 4 ticks on idle line -> no rx_valid, busy back to 0 by tick 8.
//  - rx_ready=0, send 0x11 then 0x22 -> overrun_err pulse, rx_data=0x22, rx_valid=1;
//    ready on completion cycle of a third frame -> no overrun.
//  - rst asserted mid-DATA of 0x5A -> all outputs reset next clk; next 0xC3 received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and CSR field positions.
// Used by uart_rx, uart_tx and baud_rate_gen.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } rx_state_e;

    localparam int CSR_LEN_LSB = 0;
    localparam int CSR_PAR_EN  = 2;
    localparam int CSR_PAR_ODD = 3;
    localparam int CSR_STOP2   = 4;
    localparam int CSR_DIV_LSB = 7;
    localparam int CSR_DIV_MSB = 26;

    // Frame format latched at the start edge; field order mirrors csr[4:0].
    typedef struct packed {
        logic       stop2;
        logic       par_odd;
        logic       par_en;
        logic [1:0] len;
    } rx_cfg_t;

    // Index of the last data bit: len code 0..3 maps to 4..7.
    function automatic logic [2:0] last_bit(input logic [1:0] len);
        return {1'b1, len};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake: data, status flags and valid/ready.
// The receiver is master, the consumer is slave.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset high so an idle line never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with a
// valid/ready byte output and per-frame parity, framing and overrun status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      csr,
    input  logic             tick,
    input  logic             rx,
    output logic             busy,
    uart_rx_if.master        rx_bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HALF = cnt_t'(OVERSAMPLE / 2 - 1);
    localparam cnt_t LAST = cnt_t'(OVERSAMPLE - 1);

    logic      rx_s;
    logic      fall;
    rx_state_e state;
    cnt_t      tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    rx_cfg_t   cfg;
    logic      pe_n;
    logic      fe_n;
    logic      done;
    logic      bit_end;
    logic      unused_csr;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign bit_end    = tick && (tick_cnt == LAST);
    assign busy       = (state != IDLE);
    assign unused_csr = ^csr[31:5];

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            tick_cnt           <= '0;
            bit_idx            <= '0;
            shreg              <= '0;
            cfg                <= '0;
            pe_n               <= 1'b0;
            fe_n               <= 1'b0;
            done               <= 1'b0;
            rx_bus.rx_data     <= '0;
            rx_bus.rx_valid    <= 1'b0;
            rx_bus.parity_err  <= 1'b0;
            rx_bus.frame_err   <= 1'b0;
            rx_bus.overrun_err <= 1'b0;
        end else begin
            done               <= 1'b0;
            rx_bus.overrun_err <= 1'b0;

            // A completing frame wins over an acceptance in the same cycle.
            if (done) begin
                rx_bus.rx_data     <= shreg;
                rx_bus.parity_err  <= pe_n;
                rx_bus.frame_err   <= fe_n;
                rx_bus.rx_valid    <= 1'b1;
                rx_bus.overrun_err <= rx_bus.rx_valid & ~rx_bus.rx_ready;
            end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
                rx_bus.rx_valid <= 1'b0;
            end

            if (tick && state != IDLE) begin
                tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        tick_cnt <= '0;
                        cfg      <= rx_cfg_t'(csr[CSR_STOP2:CSR_LEN_LSB]);
                    end
                end
                START: begin
                    if (tick && tick_cnt == HALF) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                            shreg   <= '0;
                            pe_n    <= 1'b0;
                            fe_n    <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == last_bit(cfg.len)) begin
                            state <= cfg.par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        pe_n  <= ((^shreg) ^ rx_s) != cfg.par_odd;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        fe_n <= ~rx_s;
                        if (cfg.stop2) begin
                            state <= STOP2;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (bit_end) begin
                        fe_n  <= fe_n | ~rx_s;
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, expected
// bytes queue up at send time and are popped when the receiver hands them over.
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        tick = 1'b0;
    logic        rx   = 1'b1;
    logic        busy;
    logic [31:0] csr;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .csr    (csr),
        .tick   (tick),
        .rx     (rx),
        .busy   (busy),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks: divisor 4, so one bit is 64 clocks.
    initial forever begin
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   vecs    = 0;
    int   errs    = 0;
    int   ovr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid && bus.rx_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(bus.rx_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rx_data", 32'(bus.rx_data), 32'(e.d));
                    check("parity_err", 32'(bus.parity_err), 32'(e.pe));
                    check("frame_err", 32'(bus.frame_err), 32'(e.fe));
                end
            end
            if (bus.overrun_err) begin
                ovr_cnt++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    function automatic logic [31:0] mk_csr(input int nb, input bit pen,
                                           input bit odd, input bit s2);
        logic [31:0] c;
        c       = '0;
        c[26:7] = 20'd4;
        c[1:0]  = 2'(nb - 5);
        c[2]    = pen;
        c[3]    = odd;
        c[4]    = s2;
        return c;
    endfunction

    task automatic bit_out(input logic b);
        rx = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) bit_out(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input int nb, input bit pen,
                        input bit odd, input bit s2, input bit flip,
                        input bit s2low);
        exp_t       e;
        logic [7:0] m;
        m    = d & 8'((1 << nb) - 1);
        e.d  = m;
        e.pe = pen & flip;
        e.fe = s2low;
        sb.push_back(e);
        bit_out(1'b0);
        for (int i = 0; i < nb; i++) bit_out(d[i]);
        if (pen) bit_out((^m) ^ odd ^ flip);
        bit_out(1'b1);
        if (s2) bit_out(~s2low);
    endtask

    // Raise ready in the cycle the receiver loads a completed frame.
    task automatic ready_on_completion();
        int n;
        n = 0;
        while (!busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_rise_timeout", 32'(n < 500), 1);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_fall_timeout", 32'(n < 2000), 1);
        bus.rx_ready = 1'b1;
    endtask

    initial begin
        csr          = mk_csr(8, 0, 0, 0);
        bus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(bus.rx_valid), 0);
        check("rst_data", 32'(bus.rx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovr", 32'(bus.overrun_err), 0);
        check("rst_perr", 32'(bus.parity_err), 0);
        check("rst_ferr", 32'(bus.frame_err), 0);
        rst = 1'b0;
        idle(1);

        send(8'hA5, 8, 0, 0, 0, 0, 0);
        idle(1);
        check("sb_8n1", sb.size(), 0);

        csr = mk_csr(7, 1, 0, 0);
        send(8'h35, 7, 1, 0, 0, 0, 0);
        idle(1);
        send(8'h35, 7, 1, 0, 0, 1, 0);
        idle(1);
        csr = mk_csr(7, 1, 1, 0);
        send(8'h35, 7, 1, 1, 0, 0, 0);
        idle(1);
        check("sb_7p1", sb.size(), 0);

        csr = mk_csr(8, 0, 0, 1);
        send(8'h3C, 8, 0, 0, 1, 0, 1);
        repeat (3 * 640) @(negedge clk);
        check("low_line_busy", 32'(busy), 0);
        check("sb_8n2", sb.size(), 0);
        idle(2);

        csr = mk_csr(8, 0, 0, 0);
        rx  = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_mid", 32'(busy), 1);
        repeat (24) @(negedge clk);
        check("glitch_busy_end", 32'(busy), 0);
        idle(1);
        check("glitch_no_out", sb.size(), 0);

        bus.rx_ready = 1'b0;
        send(8'h11, 8, 0, 0, 0, 0, 0);
        idle(1);
        send(8'h22, 8, 0, 0, 0, 0, 0);
        idle(1);
        check("ovr_pulse", ovr_cnt, 1);
        check("ovr_valid", 32'(bus.rx_valid), 1);
        check("ovr_data", 32'(bus.rx_data), 32'h22);
        fork
            send(8'h33, 8, 0, 0, 0, 0, 0);
            ready_on_completion();
        join
        idle(1);
        check("ready_no_ovr", ovr_cnt, 1);
        check("sb_ovr", sb.size(), 0);

        bit_out(1'b0);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.rx_valid), 0);
        check("mid_rst_data", 32'(bus.rx_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_perr", 32'(bus.parity_err), 0);
        check("mid_rst_ferr", 32'(bus.frame_err), 0);
        rst = 1'b0;
        idle(2);
        send(8'hC3, 8, 0, 0, 0, 0, 0);
        idle(1);
        check("sb_after_rst", sb.size(), 0);
        check("ovr_final", ovr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
